// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency data memory between two masters.
// Optional macro DMEM_ARB_PERF_EN adds grant and contention counters.
module dmem_arbiter #(
    parameter int MEM_LATENCY = 1,
    parameter int DATA_W      = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic [DATA_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [10:0]       m0_ctrl,
    output logic              m0_ready,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic [DATA_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [10:0]       m1_ctrl,
    output logic              m1_ready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [10:0]       mem_ctrl,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [63:0]       m0_grants,
    output logic [63:0]       m1_grants,
    output logic [63:0]       contention_cycles
`endif
);

    localparam int LAT = (MEM_LATENCY < 1) ? 1 : MEM_LATENCY;
    localparam int CW  = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state;
    logic              last_grant;
    logic              lat_write;
    logic [CW-1:0]     counter;
    logic              any_req;
    logic              grant_sel;
    logic [DATA_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [10:0]       sel_ctrl;
    logic              unused_regwrite;

    // A tie goes to whichever master did not win the previous grant.
    always_comb begin
        any_req   = m0_req | m1_req;
        grant_sel = (m0_req && m1_req) ? ~last_grant : m1_req;
        sel_addr  = grant_sel ? m1_addr  : m0_addr;
        sel_wdata = grant_sel ? m1_wdata : m0_wdata;
        sel_ctrl  = grant_sel ? m1_ctrl  : m0_ctrl;
    end

    assign unused_regwrite = m0_ctrl[0] ^ m1_ctrl[0];

    // mem_addr/mem_wdata double as the latched copy of the granted request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            counter    <= '0;
            lat_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_ctrl   <= '0;
            m0_ready   <= 1'b0;
            m1_ready   <= 1'b0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner      <= grant_sel;
                        last_grant <= grant_sel;
                        counter    <= CW'(LAT - 1);
                        lat_write  <= sel_ctrl[2];
                        mem_addr   <= sel_addr;
                        mem_wdata  <= sel_wdata;
                        mem_ctrl   <= {sel_ctrl[10:3], (LAT == 1) ? sel_ctrl[2] : 1'b0,
                                       sel_ctrl[1], 1'b0};
                        busy       <= 1'b1;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (counter == '0) begin
                        if (owner) m1_rdata <= mem_rdata;
                        else       m0_rdata <= mem_rdata;
                        m0_ready  <= ~owner;
                        m1_ready  <= owner;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        mem_ctrl  <= '0;
                        state     <= RESP;
                    end else begin
                        // The write strobe is raised only for the final access cycle.
                        if (counter == CW'(1)) mem_ctrl[2] <= lat_write;
                        counter <= counter - 1'b1;
                    end
                end
                RESP: begin
                    m0_ready <= 1'b0;
                    m1_ready <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DMEM_ARB_PERF_EN
    logic contend;

    // Count a cycle once when any master is left waiting, either behind an
    // in-flight transaction or by losing a tie.
    always_comb begin
        if (state != IDLE) contend = (m0_req && owner) || (m1_req && !owner);
        else               contend = m0_req && m1_req;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m0_grants         <= '0;
            m1_grants         <= '0;
            contention_cycles <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                if (grant_sel) m1_grants <= m1_grants + 64'd1;
                else           m0_grants <= m0_grants + 64'd1;
            end
            if (contend) contention_cycles <= contention_cycles + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: instance A uses MEM_LATENCY=1, instance B uses MEM_LATENCY=3.
module tb_dmem_arbiter;

    localparam logic [3:0] LOAD_WORD        = 4'd3;
    localparam logic [3:0] STORE_DOUBLEWORD = 4'd4;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_m0_req, a_m1_req, b_m0_req, b_m1_req;
    logic [63:0] m0_addr, m0_wdata, m1_addr, m1_wdata, mem_rdata;
    logic [10:0] m0_ctrl, m1_ctrl;

    logic        a_m0_ready, a_m1_ready, a_busy, a_owner;
    logic [63:0] a_m0_rdata, a_m1_rdata, a_mem_addr, a_mem_wdata;
    logic [10:0] a_mem_ctrl;
    logic        b_m0_ready, b_m1_ready, b_busy, b_owner;
    logic [63:0] b_m0_rdata, b_m1_rdata, b_mem_addr, b_mem_wdata;
    logic [10:0] b_mem_ctrl;
`ifdef DMEM_ARB_PERF_EN
    logic [63:0] a_m0_grants, a_m1_grants, a_contention;
    logic [63:0] b_m0_grants, b_m1_grants, b_contention;
`endif

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.MEM_LATENCY(1), .DATA_W(64)) u_lat1 (
        .clk(clk), .rst(rst),
        .m0_req(a_m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_ctrl(m0_ctrl),
        .m0_ready(a_m0_ready), .m0_rdata(a_m0_rdata),
        .m1_req(a_m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_ctrl(m1_ctrl),
        .m1_ready(a_m1_ready), .m1_rdata(a_m1_rdata),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_ctrl(a_mem_ctrl),
        .mem_rdata(mem_rdata), .busy(a_busy), .owner(a_owner)
`ifdef DMEM_ARB_PERF_EN
        , .m0_grants(a_m0_grants), .m1_grants(a_m1_grants), .contention_cycles(a_contention)
`endif
    );

    dmem_arbiter #(.MEM_LATENCY(3), .DATA_W(64)) u_lat3 (
        .clk(clk), .rst(rst),
        .m0_req(b_m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_ctrl(m0_ctrl),
        .m0_ready(b_m0_ready), .m0_rdata(b_m0_rdata),
        .m1_req(b_m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_ctrl(m1_ctrl),
        .m1_ready(b_m1_ready), .m1_rdata(b_m1_rdata),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_ctrl(b_mem_ctrl),
        .mem_rdata(mem_rdata), .busy(b_busy), .owner(b_owner)
`ifdef DMEM_ARB_PERF_EN
        , .m0_grants(b_m0_grants), .m1_grants(b_m1_grants), .contention_cycles(b_contention)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        n_compared++;
        if (a_mem_addr !== 64'h0 || a_mem_ctrl !== 11'h0 || a_mem_wdata !== 64'h0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_a_mem: addr=%h ctrl=%h wdata=%h required all 0", a_mem_addr, a_mem_ctrl, a_mem_wdata);
        end
        n_compared++;
        if ({a_busy, a_owner, a_m0_ready, a_m1_ready} !== 4'b0000) begin
            n_mismatched++;
            $display("[TB] FAIL reset_a_flags: busy/owner/rdy0/rdy1=%b required 0000", {a_busy, a_owner, a_m0_ready, a_m1_ready});
        end
        n_compared++;
        if (a_m0_rdata !== 64'h0 || a_m1_rdata !== 64'h0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_a_rdata: m0=%h m1=%h required 0", a_m0_rdata, a_m1_rdata);
        end
        n_compared++;
        if ({b_busy, b_owner, b_m0_ready, b_m1_ready} !== 4'b0000 || b_mem_ctrl !== 11'h0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_b: flags=%b ctrl=%h required 0", {b_busy, b_owner, b_m0_ready, b_m1_ready}, b_mem_ctrl);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_load;
        logic [10:0] exp_ctrl;
        m0_addr   = 64'h40;
        m0_ctrl   = {4'd0, LOAD_WORD, 1'b0, 1'b1, 1'b1};
        exp_ctrl  = {4'd0, LOAD_WORD, 1'b0, 1'b1, 1'b0};
        a_m0_req  = 1'b1;
        tick();
        mem_rdata = 64'hDEADBEEF;
        n_compared++;
        if (a_mem_addr !== 64'h40) begin
            n_mismatched++;
            $display("[TB] FAIL load_mem_addr: got %h required %h", a_mem_addr, 64'h40);
        end
        n_compared++;
        if (a_mem_ctrl !== exp_ctrl) begin
            n_mismatched++;
            $display("[TB] FAIL load_mem_ctrl: got %h required %h", a_mem_ctrl, exp_ctrl);
        end
        n_compared++;
        if ({a_busy, a_owner, a_m0_ready, a_m1_ready} !== 4'b1000) begin
            n_mismatched++;
            $display("[TB] FAIL load_access_flags: busy/owner/rdy0/rdy1=%b required 1000", {a_busy, a_owner, a_m0_ready, a_m1_ready});
        end
        tick();
        a_m0_req  = 1'b0;
        mem_rdata = 64'h0;
        n_compared++;
        if (a_m0_ready !== 1'b1 || a_m1_ready !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL load_ready: rdy0=%b rdy1=%b required 1 0", a_m0_ready, a_m1_ready);
        end
        n_compared++;
        if (a_m0_rdata !== 64'hDEADBEEF) begin
            n_mismatched++;
            $display("[TB] FAIL load_rdata: got %h required %h", a_m0_rdata, 64'hDEADBEEF);
        end
        n_compared++;
        if (a_mem_ctrl !== 11'h0 || a_mem_addr !== 64'h0 || a_busy !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL load_resp_mem: ctrl=%h addr=%h busy=%b required 0 0 1", a_mem_ctrl, a_mem_addr, a_busy);
        end
        tick();
        n_compared++;
        if (a_m0_ready !== 1'b0 || a_busy !== 1'b0 || a_m0_rdata !== 64'hDEADBEEF) begin
            n_mismatched++;
            $display("[TB] FAIL load_idle: rdy0=%b busy=%b rdata=%h required 0 0 deadbeef", a_m0_ready, a_busy, a_m0_rdata);
        end
    endtask

    task automatic test_round_robin;
        logic        exp_own;
        logic [63:0] exp_addr;
        do_reset();
        m0_addr  = 64'h40;
        m1_addr  = 64'h80;
        m0_ctrl  = {4'd0, LOAD_WORD, 3'b010};
        m1_ctrl  = {4'd0, LOAD_WORD, 3'b010};
        a_m0_req = 1'b1;
        a_m1_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_own  = k[0];
            exp_addr = exp_own ? 64'h80 : 64'h40;
            tick();
            n_compared++;
            if (a_owner !== exp_own || a_mem_addr !== exp_addr) begin
                n_mismatched++;
                $display("[TB] FAIL rr_grant%0d: owner=%b addr=%h required %b %h", k, a_owner, a_mem_addr, exp_own, exp_addr);
            end
            tick();
            n_compared++;
            if (a_m0_ready !== !exp_own || a_m1_ready !== exp_own) begin
                n_mismatched++;
                $display("[TB] FAIL rr_ready%0d: rdy0=%b rdy1=%b required %b %b", k, a_m0_ready, a_m1_ready, !exp_own, exp_own);
            end
            if (k == 3) begin
                a_m0_req = 1'b0;
                a_m1_req = 1'b0;
            end
            tick();
            n_compared++;
            if (a_busy !== 1'b0 || a_m0_ready !== 1'b0 || a_m1_ready !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL rr_idle%0d: busy=%b rdy0=%b rdy1=%b required 0", k, a_busy, a_m0_ready, a_m1_ready);
            end
        end
        tick();
        n_compared++;
        if (a_busy !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL rr_quiet: busy=%b required 0", a_busy);
        end
    endtask

    task automatic test_store_latency;
        logic [10:0] exp_ctrl;
        do_reset();
        m1_addr   = 64'h100;
        m1_wdata  = 64'h1122334455667788;
        m1_ctrl   = {STORE_DOUBLEWORD, 4'd0, 3'b100};
        exp_ctrl  = {STORE_DOUBLEWORD, 4'd0, 3'b100};
        mem_rdata = 64'hCAFE;
        b_m1_req  = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c == 2) m1_addr = 64'hBAD0;
            n_compared++;
            if (b_owner !== 1'b1 || b_mem_addr !== 64'h100 || b_mem_wdata !== 64'h1122334455667788) begin
                n_mismatched++;
                $display("[TB] FAIL store_bus_c%0d: owner=%b addr=%h wdata=%h required 1 100 1122334455667788", c, b_owner, b_mem_addr, b_mem_wdata);
            end
            n_compared++;
            if (b_mem_ctrl !== ((c == 3) ? exp_ctrl : {exp_ctrl[10:3], 3'b000})) begin
                n_mismatched++;
                $display("[TB] FAIL store_ctrl_c%0d: got %h required %h", c, b_mem_ctrl, (c == 3) ? exp_ctrl : {exp_ctrl[10:3], 3'b000});
            end
        end
        tick();
        b_m1_req = 1'b0;
        n_compared++;
        if (b_m1_ready !== 1'b1 || b_m0_ready !== 1'b0 || b_mem_ctrl !== 11'h0) begin
            n_mismatched++;
            $display("[TB] FAIL store_resp: rdy1=%b rdy0=%b ctrl=%h required 1 0 0", b_m1_ready, b_m0_ready, b_mem_ctrl);
        end
        n_compared++;
        if (b_m1_rdata !== 64'hCAFE) begin
            n_mismatched++;
            $display("[TB] FAIL store_rdata: got %h required %h", b_m1_rdata, 64'hCAFE);
        end
        tick();
        mem_rdata = 64'h0;
    endtask

    task automatic test_reset_mid_access;
        do_reset();
        m0_addr   = 64'h40;
        m0_ctrl   = {4'd0, LOAD_WORD, 3'b010};
        m1_addr   = 64'h100;
        m1_ctrl   = {STORE_DOUBLEWORD, 4'd0, 3'b100};
        mem_rdata = 64'h77;
        b_m1_req  = 1'b1;
        tick();
        tick();
        n_compared++;
        if (b_mem_ctrl[2] !== 1'b0 || b_busy !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL rstmid_access2: write=%b busy=%b required 0 1", b_mem_ctrl[2], b_busy);
        end
        rst      = 1'b1;
        b_m1_req = 1'b0;
        tick();
        rst = 1'b0;
        n_compared++;
        if (b_mem_ctrl !== 11'h0 || b_mem_addr !== 64'h0 || b_mem_wdata !== 64'h0) begin
            n_mismatched++;
            $display("[TB] FAIL rstmid_mem: ctrl=%h addr=%h wdata=%h required 0", b_mem_ctrl, b_mem_addr, b_mem_wdata);
        end
        n_compared++;
        if ({b_busy, b_m1_ready, b_m0_ready} !== 3'b000 || b_m1_rdata !== 64'h0) begin
            n_mismatched++;
            $display("[TB] FAIL rstmid_flags: busy/rdy1/rdy0=%b rdata1=%h required 000 0", {b_busy, b_m1_ready, b_m0_ready}, b_m1_rdata);
        end
        b_m0_req = 1'b1;
        b_m1_req = 1'b1;
        tick();
        b_m0_req = 1'b0;
        b_m1_req = 1'b0;
        n_compared++;
        if (b_owner !== 1'b0 || b_mem_addr !== 64'h40) begin
            n_mismatched++;
            $display("[TB] FAIL rstmid_tie: owner=%b addr=%h required 0 40", b_owner, b_mem_addr);
        end
        tick();
        tick();
        tick();
        n_compared++;
        if (b_m0_ready !== 1'b1 || b_m1_ready !== 1'b0 || b_m0_rdata !== 64'h77) begin
            n_mismatched++;
            $display("[TB] FAIL rstmid_after: rdy0=%b rdy1=%b rdata0=%h required 1 0 77", b_m0_ready, b_m1_ready, b_m0_rdata);
        end
        tick();
        mem_rdata = 64'h0;
    endtask

    task automatic test_fairness;
        do_reset();
        m0_addr  = 64'h40;
        m1_addr  = 64'h80;
        m0_ctrl  = {4'd0, LOAD_WORD, 3'b010};
        m1_ctrl  = {4'd0, LOAD_WORD, 3'b010};
        a_m0_req = 1'b1;
        tick();
        a_m1_req = 1'b1;
        n_compared++;
        if (a_owner !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL fair_first: owner=%b required 0", a_owner);
        end
        tick();
        tick();
        tick();
        n_compared++;
        if (a_owner !== 1'b1 || a_mem_addr !== 64'h80) begin
            n_mismatched++;
            $display("[TB] FAIL fair_m1_grant: owner=%b addr=%h required 1 80", a_owner, a_mem_addr);
        end
        tick();
        a_m1_req = 1'b0;
        n_compared++;
        if (a_m1_ready !== 1'b1 || a_m0_ready !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL fair_m1_ready: rdy1=%b rdy0=%b required 1 0", a_m1_ready, a_m0_ready);
        end
        tick();
        tick();
        n_compared++;
        if (a_owner !== 1'b0 || a_mem_addr !== 64'h40) begin
            n_mismatched++;
            $display("[TB] FAIL fair_m0_again: owner=%b addr=%h required 0 40", a_owner, a_mem_addr);
        end
        tick();
        a_m0_req = 1'b0;
        n_compared++;
        if (a_m0_ready !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL fair_m0_ready: rdy0=%b required 1", a_m0_ready);
        end
        tick();
    endtask

`ifdef DMEM_ARB_PERF_EN
    task automatic test_perf;
        do_reset();
        a_m0_req = 1'b1;
        a_m1_req = 1'b1;
        for (int k = 0; k < 11; k++) tick();
        a_m0_req = 1'b0;
        a_m1_req = 1'b0;
        tick();
        n_compared++;
        if (a_m0_grants !== 64'd2 || a_m1_grants !== 64'd2) begin
            n_mismatched++;
            $display("[TB] FAIL perf_grants: m0=%0d m1=%0d required 2 2", a_m0_grants, a_m1_grants);
        end
        n_compared++;
        if (!(a_contention > 64'd0)) begin
            n_mismatched++;
            $display("[TB] FAIL perf_contention: got %0d required > 0", a_contention);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_compared++;
        if (a_m0_grants !== 64'd0 || a_m1_grants !== 64'd0 || a_contention !== 64'd0) begin
            n_mismatched++;
            $display("[TB] FAIL perf_clear: %0d %0d %0d required 0 0 0", a_m0_grants, a_m1_grants, a_contention);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        {a_m0_req, a_m1_req, b_m0_req, b_m1_req} = 4'b0;
        {m0_addr, m0_wdata, m1_addr, m1_wdata, mem_rdata} = '0;
        m0_ctrl = '0;
        m1_ctrl = '0;
        test_reset();
        test_single_load();
        test_round_robin();
        test_store_latency();
        test_reset_mid_access();
        test_fairness();
`ifdef DMEM_ARB_PERF_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-master, single-slave arbiter for the data-memory port of the single-cycle core. It shares one data memory between the CPU data port and a second master, such as a loader/DMA or a second core.
- Each master presents address, write data and the 11-bit control word in ControlBus format.
- The arbiter picks a master round-robin, sequences a fixed-latency memory access, and returns read data with a one-cycle ready pulse.
- The CPU stalls on its own side until ready is seen.

Parameters:
- MEM_LATENCY, default 1: memory access cycles per transaction; values below 1 are treated as 1.
- DATA_W, default 64: width of address and data buses (matches `BIT_WIDTH).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- m0_req  input  1  master 0 request; held with addr/wdata/ctrl stable until m0_ready.
- m0_addr  input  DATA_W  master 0 byte address.
- m0_wdata  input  DATA_W  master 0 store data.
- m0_ctrl  input  11  {storetype[3:0], loadtype[3:0], MemWriteEn, MemReadEn, RegWriteEn}.
- m0_ready  output  1  one-cycle completion pulse for master 0.
- m0_rdata  output  DATA_W  master 0 load data; valid while m0_ready=1, then held.
- m1_req, m1_addr, m1_wdata, m1_ctrl, m1_ready, m1_rdata: same as master 0, for master 1.
- mem_addr  output  DATA_W  address to memory.
- mem_wdata  output  DATA_W  store data to memory.
- mem_ctrl  output  11  control word to memory; bit0 (RegWriteEn) always 0.
- mem_rdata  input  DATA_W  memory read data, sampled on the last ACCESS cycle.
- busy  output  1  high in ACCESS and RESP.
- owner  output  1  index of the master currently granted; holds last value in IDLE.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state=IDLE, last_grant=1 (so master 0 wins the first tie), owner=0, counter=0.
  - All outputs 0: mem_*, m*_ready, m*_rdata, busy.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - Requests sampled at the edge.
  - One req high: grant that master.
  - Both high: grant the master != last_grant.
  - On grant: latch addr/wdata/ctrl into registers, set owner and last_grant, counter=MEM_LATENCY-1, go to ACCESS.
  - No req: stay in IDLE; mem_* outputs are 0.
- ACCESS:
  - mem_addr and mem_wdata come from the latched registers.
  - mem_ctrl[1] (read) and mem_ctrl[10:3] (load/store types) are driven on every ACCESS cycle.
  - mem_ctrl[2] (write) is asserted only on the final ACCESS cycle (counter==0), giving exactly one write strobe per transaction.
  - counter decrements each cycle.
  - At counter==0: capture mem_rdata into the owner's rdata register and go to RESP.
- RESP:
  - owner's ready=1 for exactly one cycle; mem_* return to 0; next state IDLE.
- Latency: req high in IDLE cycle T gives ACCESS cycles T+1..T+MEM_LATENCY and ready at T+MEM_LATENCY+1.
  - Minimum issue-to-issue spacing is MEM_LATENCY+2 cycles.
- Requester handshake:
  - Deassert req, or present a new request, in the cycle after ready.
  - req still high in the following IDLE cycle counts as a new transaction.
  - Changes to req/addr/ctrl during ACCESS are ignored (latched copy is used).
- Transaction with neither read nor write set: still sequenced; ready pulses; no memory strobe.
- Non-owner master: ready stays 0; its rdata holds its last captured value.
- Fairness: a waiting master is granted at most one transaction after it raises req.
- Reset mid-ACCESS or mid-RESP: transaction is discarded with no ready pulse, no write strobe and no rdata update; outputs are 0 on the next cycle.

Optional Feature:
Macro: DMEM_ARB_PERF_EN
- Defined:
  - Adds outputs m0_grants (64), m1_grants (64) and contention_cycles (64).
  - Grant counters increment on each grant.
  - contention_cycles increments every cycle in which a master has req=1 but is not the owner of an in-flight transaction, or loses a tie.
  - All three counters clear on rst.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
1. MEM_LATENCY=1; m0 load: addr 0x40, ctrl read with loadtype=LOAD_WORD; mem_rdata=0xDEADBEEF on ACCESS → at T+1 mem_addr=0x40 and mem_ctrl[1]=1; at T+2 m0_ready=1 and m0_rdata=0xDEADBEEF; m1_ready=0 throughout.
2. After reset, m0 and m1 raise req in the same cycle and hold it → grant order m0, m1, m0, m1; ready pulses every 3 cycles, alternating.
3. MEM_LATENCY=3; m1 store: addr 0x100, wdata 0x1122334455667788, storetype=STORE_DOUBLEWORD → mem_ctrl[2]=1 only at T+3; mem_wdata stable T+1..T+3; m1_ready at T+4.
4. rst asserted during the 2nd ACCESS cycle of an m1 write (MEM_LATENCY=3) → no write strobe, no m1_ready, all outputs 0 next cycle; next tie is granted to m0.
5. m0 holds req continuously; m1 raises req mid-transaction → m1 is granted in the next IDLE; m0 is then granted again.
6. With DMEM_ARB_PERF_EN, run scenario 2 for 4 transactions → m0_grants=2, m1_grants=2, contention_cycles>0; rst clears all three to 0.
